// File: rtl/hc05_at_sequencer.sv
// HC-05 AT-command sequencer: raises KEY, waits the settle time, streams one command
// line plus CR LF to the UART transmitter, then parses replies for OK / ERROR / timeout.
module hc05_at_sequencer #(
    parameter int unsigned SETUP_CYCLES   = 32'd50000,
    parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       start,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       cmd_last,
    output logic       cmd_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       mode_control,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_SEND_CR = 3'd3;
    localparam logic [2:0] ST_SEND_LF = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    localparam logic [31:0] SETUP_LAST   = 32'(SETUP_CYCLES - 32'd1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [31:0] cnt_r;
    logic [1:0]  pos_r;
    logic [7:0]  b0_r;
    logic [7:0]  b1_r;
    logic [1:0]  status_r;
    logic        mode_r;
    logic        busy_r;
    logic        done_r;

    logic        line_end_s;
    logic        ok_s;
    logic        err_s;
    logic        timeout_s;

    // Reply classification: only a line-ending LF seen while waiting can produce a result
    assign line_end_s = (state_r == ST_WAIT) && rx_valid && (rx_data == CH_LF);
    assign ok_s       = line_end_s && (pos_r == 2'd2) && (b0_r == 8'h4F) && (b1_r == 8'h4B);
    assign err_s      = line_end_s && (pos_r == 2'd2) && (b0_r == 8'h45) && (b1_r == 8'h52);
    assign timeout_s  = (state_r == ST_WAIT) && (cnt_r == TIMEOUT_LAST);

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    if (start) state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
            ST_SETUP:   if (cnt_r == SETUP_LAST) state_nxt_s = ST_SEND; else state_nxt_s = ST_SETUP;
            ST_SEND:    if (cmd_valid && tx_ready && cmd_last) state_nxt_s = ST_SEND_CR;
                        else state_nxt_s = ST_SEND;
            ST_SEND_CR: if (tx_ready) state_nxt_s = ST_SEND_LF; else state_nxt_s = ST_SEND_CR;
            ST_SEND_LF: if (tx_ready) state_nxt_s = ST_WAIT; else state_nxt_s = ST_SEND_LF;
            ST_WAIT:    if (ok_s || err_s || timeout_s) state_nxt_s = ST_FINISH;
                        else state_nxt_s = ST_WAIT;
            ST_FINISH:  state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Transmit path: SEND is a combinational pass-through so the host sees tx_ready directly
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        cmd_ready = 1'b0;
        case (state_r)
            ST_SEND: begin
                tx_valid  = cmd_valid;
                tx_data   = cmd_data;
                cmd_ready = tx_ready;
            end
            ST_SEND_CR: begin
                tx_valid = 1'b1;
                tx_data  = CH_CR;
            end
            ST_SEND_LF: begin
                tx_valid = 1'b1;
                tx_data  = CH_LF;
            end
            default: begin
                tx_valid  = 1'b0;
                tx_data   = 8'h00;
                cmd_ready = 1'b0;
            end
        endcase
    end

    // State, shared setup/timeout counter and flag outputs registered from the next state
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 32'd0;
            mode_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= 32'd0;
            end else if ((state_r == ST_SETUP) || (state_r == ST_WAIT)) begin
                cnt_r <= cnt_r + 32'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            mode_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FINISH);
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_FINISH);
        end
    end

    // Result register; an LF result takes priority over a coincident timeout
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            status_r <= 2'b00;
        end else if (ok_s) begin
            status_r <= 2'b00;
        end else if (err_s) begin
            status_r <= 2'b01;
        end else if (timeout_s) begin
            status_r <= 2'b10;
        end else begin
            status_r <= status_r;
        end
    end

    // Line parser: keeps the first two non-CR bytes of each reply line
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pos_r <= 2'd0;
            b0_r  <= 8'h00;
            b1_r  <= 8'h00;
        end else if (state_r != ST_WAIT) begin
            pos_r <= 2'd0;
            b0_r  <= 8'h00;
            b1_r  <= 8'h00;
        end else if (rx_valid && (rx_data == CH_LF)) begin
            pos_r <= 2'd0;
        end else if (rx_valid && (rx_data != CH_CR)) begin
            if (pos_r == 2'd0) begin
                b0_r <= rx_data;
            end else if (pos_r == 2'd1) begin
                b1_r <= rx_data;
            end
            if (pos_r != 2'd2) begin
                pos_r <= pos_r + 2'd1;
            end
        end
    end

    assign mode_control = mode_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign status       = status_r;

endmodule

// File: tb/tb_hc05_at_sequencer.sv
// Randomized self-checking bench for hc05_at_sequencer; expectations come from a
// line-level reply model and the command byte list.
module tb_hc05_at_sequencer;

    localparam int SETUP = 4;
    localparam int TMO   = 100;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       start;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_last;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       mode_control;
    logic       busy;
    logic       done;
    logic [1:0] status;

    always #5 clk_clk = ~clk_clk;

    hc05_at_sequencer #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .mode_control(mode_control),
        .busy(busy), .done(done), .status(status)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cmd_q[$];
    logic [7:0] rsp_q[$];
    int         rsp_rel[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // In stimulus strings '~' stands for CR and '|' for LF
    function automatic logic [7:0] map_ch(input byte c);
        if (c == "~") return 8'h0D;
        else if (c == "|") return 8'h0A;
        else return 8'(c);
    endfunction

    task automatic set_cmd(input string s);
        cmd_q.delete();
        for (int i = 0; i < s.len(); i++) cmd_q.push_back(map_ch(s[i]));
    endtask

    // Reply bytes land at WAIT_RSP-relative cycles starting at first_rel, gaps of 1..max_gap+1
    task automatic set_reply(input string s, input int first_rel, input int max_gap);
        int r;
        r = first_rel;
        rsp_q.delete();
        rsp_rel.delete();
        for (int i = 0; i < s.len(); i++) begin
            rsp_q.push_back(map_ch(s[i]));
            rsp_rel.push_back(r);
            r += 1 + int'($urandom_range(0, max_gap));
        end
    endtask

    // Reference: split reply into lines, first line starting "OK"/"ER" inside the timeout window wins
    task automatic model_reply(output logic [1:0] st, output int rel);
        logic [7:0] line[$];
        st  = 2'b10;
        rel = TMO;
        for (int i = 0; i < rsp_q.size(); i++) begin
            if (rsp_rel[i] >= TMO) break;
            if (rsp_q[i] == 8'h0A) begin
                if (line.size() >= 2 && line[0] == "O" && line[1] == "K") begin
                    st = 2'b00; rel = rsp_rel[i] + 1; return;
                end
                if (line.size() >= 2 && line[0] == "E" && line[1] == "R") begin
                    st = 2'b01; rel = rsp_rel[i] + 1; return;
                end
                line.delete();
            end else if (rsp_q[i] != 8'h0D) begin
                line.push_back(rsp_q[i]);
            end
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; cmd_last = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    // One transaction; abort_rel >= 0 pulls reset that many cycles into WAIT_RSP
    task automatic run_txn(input string tag, input bit rnd, input int abort_rel);
        logic [7:0] exp_tx[$];
        int cmd_n, tx_idx, cmd_idx, rsp_idx, wait_t, done_t, done_cnt, exp_rel;
        logic [1:0] exp_st;
        bit held, prev_stall;
        logic [7:0] prev_data;
        exp_tx = cmd_q;
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
        cmd_n = cmd_q.size();
        tx_idx = 0; cmd_idx = 0; rsp_idx = 0; wait_t = -1; done_t = -1; done_cnt = 0;
        held = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        model_reply(exp_st, exp_rel);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk_clk);
            start = (t == 0) || (rnd && t == SETUP + 2);
            if (!held) held = (cmd_idx < cmd_n) && (!rnd || $urandom_range(0, 2) != 0);
            cmd_valid = held;
            cmd_data  = (cmd_idx < cmd_n) ? cmd_q[cmd_idx] : 8'h00;
            cmd_last  = (cmd_idx == cmd_n - 1);
            tx_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_valid  = 1'b0;
            rx_data   = 8'h00;
            if (wait_t >= 0 && rsp_idx < rsp_q.size() && t - wait_t == rsp_rel[rsp_idx]) begin
                rx_valid = 1'b1;
                rx_data  = rsp_q[rsp_idx];
                rsp_idx++;
            end
            if (abort_rel >= 0 && wait_t >= 0 && t - wait_t == abort_rel) begin
                reset_reset_n = 1'b0;
                #1;
                check_eq({tag, "_rst_mode"}, 32'(mode_control), 32'd0);
                check_eq({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check_eq({tag, "_rst_status"}, 32'(status), 32'd0);
                check_eq({tag, "_rst_done"}, 32'(done), 32'd0);
                idle_inputs();
                @(negedge clk_clk);
                reset_reset_n = 1'b1;
                return;
            end
            #1;
            if (t == 1) begin
                check_eq({tag, "_mode_on"}, 32'(mode_control), 32'd1);
                check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
            end
            if (t == SETUP) check_eq({tag, "_txv_early"}, 32'(tx_valid), 32'd0);
            if (t == SETUP + 1 && !rnd) check_eq({tag, "_txv_first"}, 32'(tx_valid), 32'd1);
            if (prev_stall) begin
                check_eq({tag, "_stall_valid"}, 32'(tx_valid), 32'd1);
                check_eq({tag, "_stall_data"}, 32'(tx_data), 32'(prev_data));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_idx < exp_tx.size()) check_eq({tag, "_tx_byte"}, 32'(tx_data), 32'(exp_tx[tx_idx]));
                else check_eq({tag, "_tx_extra"}, 32'(tx_idx), 32'(exp_tx.size()));
                tx_idx++;
                if (tx_idx == exp_tx.size()) wait_t = t + 1;
            end
            if (cmd_valid && cmd_ready) begin
                cmd_idx++;
                held = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_t = t;
                    check_eq({tag, "_done_lat"}, 32'(t - wait_t), 32'(exp_rel));
                    check_eq({tag, "_status"}, 32'(status), 32'(exp_st));
                    check_eq({tag, "_mode_off"}, 32'(mode_control), 32'd0);
                    check_eq({tag, "_busy_fin"}, 32'(busy), 32'd1);
                end
            end
            if (done_t >= 0 && t == done_t + 1) check_eq({tag, "_idle"}, 32'(busy), 32'd0);
            if (done_t >= 0 && t == done_t + 3) break;
        end
        check_eq({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_tx_count"}, 32'(tx_idx), 32'(exp_tx.size()));
        idle_inputs();
    endtask

    // Bytes arriving while idle must not disturb the held result
    task automatic stray_bytes(input string tag, input logic [1:0] held_st);
        set_reply("OK~|", 0, 0);
        for (int i = 0; i < rsp_q.size(); i++) begin
            @(negedge clk_clk);
            rx_valid = 1'b1;
            rx_data  = rsp_q[i];
            #1;
            check_eq({tag, "_done"}, 32'(done), 32'd0);
        end
        @(negedge clk_clk);
        rx_valid = 1'b0;
        #1;
        check_eq({tag, "_status"}, 32'(status), 32'(held_st));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        #1;
        check_eq("rst_mode", 32'(mode_control), 32'd0);
        check_eq("rst_txv", 32'(tx_valid), 32'd0);
        check_eq("rst_txd", 32'(tx_data), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_status", 32'(status), 32'd0);
        reset_reset_n = 1'b1;

        set_cmd("AT");
        set_reply("OK~|", 3, 0);
        run_txn("s1_ok", 1'b0, -1);

        set_reply("+VERSION:2.0~|OK~|", 2, 1);
        run_txn("s2_skip", 1'b0, -1);

        set_reply("ERROR:(0)~|", 1, 2);
        run_txn("s3_err", 1'b0, -1);

        set_reply("", 0, 0);
        run_txn("s4_tmo", 1'b0, -1);
        stray_bytes("s4_stray", 2'b10);

        set_reply("~|K~|OK~|", 91, 0);
        run_txn("lf_at_last", 1'b0, -1);

        set_reply("ER~|", 97, 0);
        run_txn("lf_after_tmo", 1'b0, -1);

        set_cmd("AT+NAME?");
        set_reply("OK~|", 0, 3);
        run_txn("s5_stall", 1'b1, -1);

        set_cmd("AT");
        set_reply("ER~|", 7, 0);
        run_txn("pre_abort", 1'b0, -1);
        set_reply("", 0, 0);
        run_txn("s6_abort", 1'b0, 10);
        set_reply("OK~|", 4, 0);
        run_txn("s6_after", 1'b0, -1);

        for (int k = 0; k < 8; k++) begin
            int len;
            len = int'($urandom_range(1, 5));
            cmd_q.delete();
            for (int i = 0; i < len; i++) cmd_q.push_back(8'($urandom_range(65, 90)));
            case ($urandom_range(0, 4))
                0:       set_reply("OK~|", int'($urandom_range(0, 20)), 3);
                1:       set_reply("ERROR~|", int'($urandom_range(0, 20)), 3);
                2:       set_reply("+ADDR:1~|OK~|", int'($urandom_range(0, 20)), 3);
                3:       set_reply("~|K~|ER~|", int'($urandom_range(0, 20)), 3);
                default: set_reply("O|OK|", int'($urandom_range(0, 20)), 3);
            endcase
            run_txn("rand", 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hc05_at_sequencer.md
Name: hc05_at_sequencer

Overview:
- Sequences AT-command transactions to the HC-05 Bluetooth module.
- Drives the module's mode_control (KEY) pin high to enter AT mode and waits a settle time.
- Streams one command line to the UART transmitter, appending CR LF, then parses UART receiver lines for OK, ERROR or a timeout.
- Sits between the key/host logic and the HC-05 UART in the Bluetooth master design.

Parameters:
SETUP_CYCLES, 50000, clocks mode_control is held high before the first command byte is sent (1 ms at 50 MHz); must be >=1
TIMEOUT_CYCLES, 50000000, maximum clocks spent in WAIT_RSP before reporting timeout (1 s at 50 MHz); must be >=1

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run one transaction; sampled only in IDLE
cmd_data  in  8  command byte, without CR LF
cmd_valid  in  1  cmd_data valid
cmd_last  in  1  marks the final command byte
cmd_ready  out  1  command byte accepted this cycle
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte
rx_data  in  8  byte from UART receiver
rx_valid  in  1  rx_data valid for one cycle; no backpressure
mode_control  out  1  HC-05 KEY pin; 1 = AT mode
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a transaction ends
status  out  2  result: 00 OK, 01 ERROR, 10 TIMEOUT; updated with done, held until the next done

Behaviour:
- Reset values: mode_control=0, tx_valid=0, tx_data=0, cmd_ready=0, busy=0, done=0, status=00. State is IDLE and all counters are 0.
- Reset mid-transaction returns the block to IDLE immediately and drops mode_control.
- States: IDLE, SETUP, SEND, SEND_CR, SEND_LF, WAIT_RSP, FINISH.
- IDLE: on start=1, go to SETUP. start is ignored in every other state.
- SETUP:
  - mode_control=1 from the first SETUP cycle.
  - Counter runs 0..SETUP_CYCLES-1, then the state moves to SEND.
  - tx_valid first rises exactly SETUP_CYCLES+1 clocks after the start cycle.
- SEND (pass-through):
  - tx_valid=cmd_valid, tx_data=cmd_data, cmd_ready=tx_ready.
  - A byte transfers when cmd_valid&&tx_ready.
  - A transfer with cmd_last=1 moves the state to SEND_CR.
  - cmd_valid low simply stalls SEND; there is no timeout in SEND.
- SEND_CR, SEND_LF: tx_valid=1 with tx_data=0x0D, then 0x0A. Each state advances on tx_ready, and tx_data is held stable while tx_ready=0. After LF the state moves to WAIT_RSP, and the timeout counter and line parser clear.
- Line parser (WAIT_RSP only; rx bytes in any other state are discarded):
  - Position counter pos saturates at 2. b0 and b1 capture the first two non-CR bytes of a line.
  - 0x0D is ignored. 0x0A ends the line.
  - On line end: b0,b1="OK" gives status 00; "ER" gives status 01; either result moves the state to FINISH.
  - Any other line (e.g. "+NAME:x", or an empty line) is ignored. pos clears and waiting continues.
- Timeout: the counter increments every WAIT_RSP cycle and is not reset by ignored lines. On reaching TIMEOUT_CYCLES-1 with no result, status becomes 10 and the state moves to FINISH.
  - If the last timeout cycle coincides with a completing LF, the LF result wins.
- FINISH (one cycle): done=1, mode_control=0, busy=1. The next cycle is IDLE, so a new start is accepted no earlier than the cycle after done.
- Counters are 32-bit unsigned; no wrap occurs within the legal parameter range.

Test Plan:
All scenarios use SETUP_CYCLES=4, TIMEOUT_CYCLES=100.
1. Start with command "AT", tx_ready=1, reply "OK\r\n" -> mode_control high 1 clk after start; tx bytes 0x41,0x54,0x0D,0x0A with first tx_valid at start+5; done pulse with status=00; mode_control=0 on done.
2. Reply "+VERSION:2.0\r\nOK\r\n" -> first line ignored, status=00.
3. Reply "ERROR:(0)\r\n" -> status=01, done pulses once.
4. No reply -> done exactly 100 clks after WAIT_RSP entry, status=10; rx bytes arriving after done are ignored.
5. tx_ready toggled randomly, cmd_valid gapped, second start pulsed during SEND -> byte order preserved, tx_data stable while stalled, second start ignored, exactly one done.
6. reset_reset_n asserted during WAIT_RSP -> mode_control=0, busy=0 and status=00 immediately; the next start runs a full normal transaction.
